apb_timer_multi: RTL and testbench
==================================

# apb_timer_multi

Parametrised multi-channel APB timer peripheral: NUM_CH independent down-counters sharing one programmable prescaler, each with auto-reload or one-shot mode, a sticky expiry flag and a maskable interrupt. It has a native APB slave port, so no strobe-conversion layer is needed. It sits on the peripheral APB bus and drives per-channel IRQ lines plus an OR-ed summary line into the interrupt controller.

## Interface
- NUM_CH, 4, number of timer channels, 1..8
- CNT_W, 32, counter/LOAD width, 8..32
- PRESC_W, 16, prescaler width, 1..32
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low; one clock, no other clock domains
- apb_timer_psel  in  1  peripheral select
- apb_timer_paddr  in  12  byte address (bits [1:0] ignored)
- apb_timer_penable  in  1  access phase
- apb_timer_pwrite  in  1  1 = write
- apb_timer_pwdata  in  32  write data
- timer_apb_prdata  out  32  read data
- timer_apb_pready  out  1  constant 1 (zero wait states)
- timer_apb_pslverr  out  1  error response
- timer_irq  out  NUM_CH  per-channel interrupt
- timer_irq_any  out  1  OR of timer_irq

## Operation
- Channel i register block at 0x10*i: CTRL +0x0 (bit0 EN, bit1 ONESHOT, bit2 IE; RW), LOAD +0x4 (RW, CNT_W bits), COUNT +0x8 (RO), STATUS +0xC (bit0 EXP, write-1-to-clear).
- Globals: PRESC 0x100 (RW, PRESC_W bits), IRQSTAT 0x104 (RO, bit i = EXP of channel i), START 0x108 (WO; bit i set = restart channel i: COUNT<=LOAD, EN<=1, all selected channels in the same cycle).
- Unused upper bits read 0, writes to them ignored; COUNT and IRQSTAT writes ignored.
- Write commits on psel & penable & pwrite. Reads are combinational from paddr; prdata = 0 when psel low.
- pslverr = 1 during access phase for: channel index >= NUM_CH, offset outside the map, or a write to 0x104; no register changes on an error write. Otherwise 0.
- Prescaler: down-counter PCNT; on PCNT==0 emit one-cycle tick and reload PCNT<=PRESC, else decrement. A PRESC write also sets PCNT<=new value.
- Channel on tick with EN=1: if COUNT!=0, COUNT<=COUNT-1; if COUNT==0, EXP<=1 and either COUNT<=LOAD (auto-reload) or EN<=0 with COUNT held at 0 (ONESHOT).
- EN 0->1 via CTRL write loads COUNT<=LOAD in the same edge. EN 1->0 freezes COUNT. A CTRL write keeping EN=1 does not reload.
- LOAD write while running takes effect at the next reload only.
- timer_irq[i] = EXP[i] & IE[i]; timer_irq_any = |timer_irq.
- Simultaneous events: hardware EXP set wins over a W1C in the same cycle. START wins over a same-cycle expiry (COUNT<=LOAD, EN stays 1). A CTRL write and a START to the same channel cannot coincide (a single APB access).

## Timing
- Reset (async assert, sync-to-clk release): all registers 0, PCNT=0, tick every cycle; prdata=0, pready=1, pslverr=0, timer_irq=0, timer_irq_any=0.
- Tick period = PRESC+1 cycles. Auto-reload expiry period = (LOAD+1)*(PRESC+1) cycles.
- EXP and timer_irq assert on the clock edge following the tick at which COUNT==0.
- W1C clears EXP/timer_irq at the write's commit edge. IE changes affect timer_irq combinationally from the flops.
- Reset asserted mid-count clears all state immediately. No pending expiry survives reset.
- LOAD=0 auto-reload: expiry on every tick. LOAD=0 one-shot: expiry on the first tick, then EN=0.

## Test plan
- Reset values: after rst_n release, read every register -> 0. pready=1, irq=0.
- PRESC=0, ch0 LOAD=3, CTRL=0x5 -> timer_irq[0] rises 4 cycles after the enable edge and again every 4 cycles after a W1C. COUNT reads 3,2,1,0,3…
- PRESC=9, ch1 LOAD=1, CTRL=0x7 (one-shot) -> a single expiry after 20 cycles, then CTRL.EN reads 0, COUNT=0, no further EXP.
- W1C to STATUS on the exact expiry cycle -> EXP remains 1. W1C one cycle later -> timer_irq_any falls.
- START=0xF with channels loaded 5,6,7,8 -> all counters load on the same edge. Expiries are spaced 1 tick apart.
- Reads/writes to 0x40 with NUM_CH=4, 0x1F0, and a write to 0x104 -> pslverr=1, state unchanged. A legal access -> pslverr=0.

Source files
------------

// File: rtl/apb_timer_multi.sv
// Multi-channel APB timer: NUM_CH down-counters share one prescaler tick; each channel
// has auto-reload or one-shot mode, a sticky W1C expiry flag and a maskable interrupt.
module apb_timer_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              apb_timer_psel,
  input  logic [11:0]       apb_timer_paddr,
  input  logic              apb_timer_penable,
  input  logic              apb_timer_pwrite,
  input  logic [31:0]       apb_timer_pwdata,
  output logic [31:0]       timer_apb_prdata,
  output logic              timer_apb_pready,
  output logic              timer_apb_pslverr,
  output logic [NUM_CH-1:0] timer_irq,
  output logic              timer_irq_any
);

  // APB handshake: a transfer completes in its access phase (psel & penable) with
  // pready tied high; writes commit on that clock edge, reads are combinational.
  logic              access, err, wr_ok;
  logic [3:0]        ch_sel;
  logic [1:0]        reg_off;
  logic              in_ch, addr_ok, sel_presc, sel_irqstat, sel_start;
  logic [NUM_CH-1:0] ch_hit;
  logic              unused_addr_bits;

  assign ch_sel           = apb_timer_paddr[7:4];
  assign reg_off          = apb_timer_paddr[3:2];
  assign unused_addr_bits = ^apb_timer_paddr[1:0];

  always_comb begin
    in_ch       = 1'b0;
    addr_ok     = 1'b0;
    sel_presc   = 1'b0;
    sel_irqstat = 1'b0;
    sel_start   = 1'b0;
    if (apb_timer_paddr[11:8] == 4'h0) begin
      in_ch   = 1'b1;
      addr_ok = (32'(ch_sel) < 32'(NUM_CH));
    end else if (apb_timer_paddr[11:8] == 4'h1) begin
      case (apb_timer_paddr[7:2])
        6'h00:   begin sel_presc   = 1'b1; addr_ok = 1'b1; end
        6'h01:   begin sel_irqstat = 1'b1; addr_ok = 1'b1; end
        6'h02:   begin sel_start   = 1'b1; addr_ok = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = in_ch && (ch_sel == 4'(i));
    end
  end

  assign err               = ~addr_ok | (apb_timer_pwrite & sel_irqstat);
  assign access            = apb_timer_psel & apb_timer_penable;
  assign wr_ok             = access & apb_timer_pwrite & ~err;
  assign timer_apb_pslverr = access & err;
  assign timer_apb_pready  = 1'b1;

  // Shared prescaler: tick whenever PCNT is zero, then reload from PRESC.
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic               tick;

  assign tick = (pcnt_q == '0);

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = tick ? presc_q : (pcnt_q - PRESC_W'(1));
    if (wr_ok && sel_presc) begin
      presc_d = apb_timer_pwdata[PRESC_W-1:0];
      pcnt_d  = apb_timer_pwdata[PRESC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  logic [NUM_CH-1:0] en_v, os_v, ie_v, exp_v;
  logic [CNT_W-1:0]  cnt_v  [NUM_CH];
  logic [CNT_W-1:0]  load_v [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             en_q, en_d, os_q, os_d, ie_q, ie_d, exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, load_q, load_d;
    logic             wr_ctrl, wr_load, wr_status, start;

    assign wr_ctrl   = wr_ok & ch_hit[g] & (reg_off == 2'd0);
    assign wr_load   = wr_ok & ch_hit[g] & (reg_off == 2'd1);
    assign wr_status = wr_ok & ch_hit[g] & (reg_off == 2'd3);
    assign start     = wr_ok & sel_start & apb_timer_pwdata[g];

    // Later assignments take priority: START beats expiry, expiry set beats W1C.
    always_comb begin
      en_d   = en_q;
      os_d   = os_q;
      ie_d   = ie_q;
      cnt_d  = cnt_q;
      load_d = load_q;
      exp_d  = exp_q;
      if (wr_status && apb_timer_pwdata[0]) exp_d = 1'b0;
      if (tick && en_q) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          exp_d = 1'b1;
          if (os_q) en_d  = 1'b0;
          else      cnt_d = load_q;
        end
      end
      if (wr_load) load_d = apb_timer_pwdata[CNT_W-1:0];
      if (wr_ctrl) begin
        en_d = apb_timer_pwdata[0];
        os_d = apb_timer_pwdata[1];
        ie_d = apb_timer_pwdata[2];
        if (apb_timer_pwdata[0] && !en_q) cnt_d = load_q;
      end
      if (start) begin
        cnt_d = load_q;
        en_d  = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q   <= 1'b0;
        os_q   <= 1'b0;
        ie_q   <= 1'b0;
        exp_q  <= 1'b0;
        cnt_q  <= '0;
        load_q <= '0;
      end else begin
        en_q   <= en_d;
        os_q   <= os_d;
        ie_q   <= ie_d;
        exp_q  <= exp_d;
        cnt_q  <= cnt_d;
        load_q <= load_d;
      end
    end

    assign en_v[g]      = en_q;
    assign os_v[g]      = os_q;
    assign ie_v[g]      = ie_q;
    assign exp_v[g]     = exp_q;
    assign cnt_v[g]     = cnt_q;
    assign load_v[g]    = load_q;
    assign timer_irq[g] = exp_q & ie_q;
  end

  assign timer_irq_any = |timer_irq;

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (apb_timer_psel && addr_ok) begin
      if (sel_presc)   rdata[PRESC_W-1:0] = presc_q;
      if (sel_irqstat) rdata[NUM_CH-1:0]  = exp_v;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_hit[i]) begin
          case (reg_off)
            2'd0:    rdata[2:0]       = {ie_v[i], os_v[i], en_v[i]};
            2'd1:    rdata[CNT_W-1:0] = load_v[i];
            2'd2:    rdata[CNT_W-1:0] = cnt_v[i];
            default: rdata[0]         = exp_v[i];
          endcase
        end
      end
    end
  end

  assign timer_apb_prdata = rdata;

endmodule

// File: tb/tb_apb_timer_multi.sv
// Directed bench for apb_timer_multi: APB driver tasks push expected responses into a
// queue that a bus monitor pops; interrupt timing is checked against hand-derived cycle counts.
module tb_apb_timer_multi;
  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 32;
  localparam int PRESC_W = 16;

  localparam logic [11:0] A_PRESC   = 12'h100;
  localparam logic [11:0] A_IRQSTAT = 12'h104;
  localparam logic [11:0] A_START   = 12'h108;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0]       paddr = '0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic [NUM_CH-1:0] timer_irq;
  logic              timer_irq_any;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  logic [33:0] exp_q[$];
  string       name_q[$];

  apb_timer_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .apb_timer_psel    (psel),
    .apb_timer_paddr   (paddr),
    .apb_timer_penable (penable),
    .apb_timer_pwrite  (pwrite),
    .apb_timer_pwdata  (pwdata),
    .timer_apb_prdata  (prdata),
    .timer_apb_pready  (pready),
    .timer_apb_pslverr (pslverr),
    .timer_irq         (timer_irq),
    .timer_irq_any     (timer_irq_any)
  );

  // Clock / reset: posedges at 5+10n, inputs change on negedges.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [11:0] ch_addr(input int ch, input int off);
    return 12'(ch * 16 + off);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic err,
                           input string n);
    exp_q.push_back({1'b0, err, 32'h0});
    name_q.push_back(n);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, input logic [31:0] d, input logic err,
                          input string n);
    exp_q.push_back({1'b1, err, d});
    name_q.push_back(n);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Bus monitor: samples each access phase just before the committing posedge.
  always @(negedge clk) begin
    logic [33:0] e;
    string       n;
    #2;
    if (psel && penable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access: addr=%h with no expected response queued", paddr);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (pready !== 1'b1 || pslverr !== e[32] || (e[33] && prdata !== e[31:0])) begin
          errors++;
          $display("FAIL %s: prdata=%h pslverr=%b pready=%b, required prdata=%h pslverr=%b pready=1",
                   n, prdata, pslverr, pready, e[33] ? e[31:0] : prdata, e[32]);
        end
      end
    end
  end

  initial begin
    int m_rise;
    int rise [NUM_CH];
    int unsigned c0;

    repeat (3) @(negedge clk);
    chk("in_reset_irq", 32'(timer_irq), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pready", 32'(pready), 32'h1);
    chk("reset_pslverr", 32'(pslverr), 32'h0);
    chk("reset_prdata_idle", prdata, 32'h0);
    chk("reset_irq", 32'(timer_irq), 32'h0);
    chk("reset_irq_any", 32'(timer_irq_any), 32'h0);
    for (int c = 0; c < NUM_CH; c++)
      for (int o = 0; o < 4; o++)
        apb_read(ch_addr(c, o * 4), 32'h0, 1'b0, $sformatf("reset_ch%0d_off%0h", c, o * 4));
    apb_read(A_PRESC, 32'h0, 1'b0, "reset_presc");
    apb_read(A_IRQSTAT, 32'h0, 1'b0, "reset_irqstat");
    apb_read(A_START, 32'h0, 1'b0, "reset_start");

    // ch0 auto-reload, PRESC=0, LOAD=3: expiry every 4 cycles after the enable edge.
    apb_write(A_PRESC, 32'd0, 1'b0, "wr_presc0");
    apb_write(ch_addr(0, 4), 32'd3, 1'b0, "wr_load0");
    apb_write(ch_addr(0, 0), 32'h5, 1'b0, "wr_ctrl0_en");
    chk("ch0_irq_at_enable", 32'(timer_irq[0]), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("ch0_irq_cycle%0d", k), 32'(timer_irq[0]), (k == 4) ? 32'h1 : 32'h0);
    end
    apb_write(ch_addr(0, 12), 32'h1, 1'b0, "w1c0_midperiod");
    chk("ch0_irq_any_after_w1c", 32'(timer_irq_any), 32'h0);
    @(negedge clk);
    chk("ch0_irq_next_expiry", 32'(timer_irq[0]), 32'h1);
    @(negedge clk);
    apb_write(ch_addr(0, 12), 32'h1, 1'b0, "w1c0_on_expiry");
    chk("ch0_exp_set_beats_w1c", 32'(timer_irq[0]), 32'h1);
    apb_write(ch_addr(0, 12), 32'h1, 1'b0, "w1c0_after_expiry");
    chk("ch0_irq_any_falls", 32'(timer_irq_any), 32'h0);

    // COUNT sequence: PRESC=2 gives one tick per APB read, so reads walk 3,2,1,0,3.
    apb_write(ch_addr(0, 0), 32'h0, 1'b0, "wr_ctrl0_off");
    apb_write(A_PRESC, 32'd2, 1'b0, "wr_presc2");
    apb_write(ch_addr(0, 0), 32'h5, 1'b0, "wr_ctrl0_en2");
    apb_read(ch_addr(0, 8), 32'd3, 1'b0, "count0_a");
    apb_read(ch_addr(0, 8), 32'd2, 1'b0, "count0_b");
    apb_read(ch_addr(0, 8), 32'd1, 1'b0, "count0_c");
    apb_read(ch_addr(0, 8), 32'd0, 1'b0, "count0_d");
    apb_read(ch_addr(0, 8), 32'd3, 1'b0, "count0_reload");
    apb_write(ch_addr(0, 0), 32'h0, 1'b0, "wr_ctrl0_off2");
    apb_write(ch_addr(0, 12), 32'h1, 1'b0, "w1c0_cleanup");
    apb_read(ch_addr(0, 12), 32'h0, 1'b0, "status0_cleared");

    // ch1 one-shot, PRESC=9, LOAD=1, enabled on a tick edge: expiry 20 cycles later.
    apb_write(ch_addr(1, 4), 32'd1, 1'b0, "wr_load1");
    apb_write(A_PRESC, 32'd9, 1'b0, "wr_presc9");
    repeat (7) @(negedge clk);
    apb_write(ch_addr(1, 0), 32'h7, 1'b0, "wr_ctrl1_oneshot");
    m_rise = -1;
    for (int m = 1; m <= 60; m++) begin
      @(negedge clk);
      if (timer_irq[1] && m_rise < 0) m_rise = m;
    end
    chk("ch1_oneshot_delay", 32'(m_rise), 32'd20);
    chk("ch1_irq_any", 32'(timer_irq_any), 32'h1);
    apb_read(ch_addr(1, 0), 32'h6, 1'b0, "ctrl1_en_cleared");
    apb_read(ch_addr(1, 8), 32'h0, 1'b0, "count1_held0");
    apb_read(ch_addr(1, 12), 32'h1, 1'b0, "status1_exp");
    apb_read(A_IRQSTAT, 32'h2, 1'b0, "irqstat_ch1");
    apb_write(ch_addr(1, 0), 32'h2, 1'b0, "wr_ctrl1_ie_off");
    chk("ch1_irq_masked", 32'(timer_irq), 32'h0);
    apb_write(ch_addr(1, 12), 32'h1, 1'b0, "w1c1");
    repeat (40) @(negedge clk);
    chk("ch1_no_second_expiry", 32'(timer_irq), 32'h0);
    apb_read(ch_addr(1, 12), 32'h0, 1'b0, "status1_stays_clear");

    // START restarts all four channels together; expiries land one tick (100 cycles) apart.
    for (int c = 0; c < NUM_CH; c++) begin
      apb_write(ch_addr(c, 0), 32'h4, 1'b0, $sformatf("wr_ctrl%0d_ie", c));
      apb_write(ch_addr(c, 4), 32'(5 + c), 1'b0, $sformatf("wr_load%0d", c));
    end
    apb_write(A_PRESC, 32'd99, 1'b0, "wr_presc99");
    apb_write(A_START, 32'hF, 1'b0, "wr_start");
    c0 = cyc;
    for (int c = 0; c < NUM_CH; c++)
      apb_read(ch_addr(c, 8), 32'(5 + c), 1'b0, $sformatf("start_count%0d", c));
    for (int c = 0; c < NUM_CH; c++) rise[c] = -1;
    for (int m = 0; m < 1200; m++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++)
        if (timer_irq[c] && rise[c] < 0) rise[c] = int'(cyc - c0);
    end
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("start_expiry_ch%0d", c), 32'(rise[c]), 32'(597 + 100 * c));
    apb_read(A_IRQSTAT, 32'hF, 1'b0, "irqstat_all");

    // Error responses leave state untouched.
    apb_read(12'h040, 32'h0, 1'b1, "err_rd_ch4");
    apb_write(12'h044, 32'hAA, 1'b1, "err_wr_ch4_load");
    apb_read(12'h1F0, 32'h0, 1'b1, "err_rd_1f0");
    apb_write(12'h1F0, 32'h1, 1'b1, "err_wr_1f0");
    apb_write(A_IRQSTAT, 32'h0, 1'b1, "err_wr_irqstat");
    apb_read(A_IRQSTAT, 32'hF, 1'b0, "irqstat_unchanged");
    apb_read(ch_addr(0, 4), 32'd5, 1'b0, "load0_unaliased");
    apb_read(A_PRESC, 32'd99, 1'b0, "presc_unchanged");

    // Reset mid-count clears everything at once.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_irq", 32'(timer_irq), 32'h0);
    chk("midreset_irq_any", 32'(timer_irq_any), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apb_read(A_IRQSTAT, 32'h0, 1'b0, "post_reset_irqstat");
    apb_read(ch_addr(0, 8), 32'h0, 1'b0, "post_reset_count0");
    apb_read(ch_addr(0, 0), 32'h0, 1'b0, "post_reset_ctrl0");
    apb_read(A_PRESC, 32'h0, 1'b0, "post_reset_presc");

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
